// File: rtl/eth_rx_dispatch.sv
// GMII receive front end: strips preamble, filters on MAC/IP, classifies ARP/ICMP/UDP and streams the payload.
// Latency: every output is registered, one cycle after the GMII byte that caused it.
// Backpressure: none; GMII cannot be stalled, so the consumer must take every pay_en byte as it arrives.
module eth_rx_dispatch #(
    parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
    parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd10}
) (
    input  logic        gmii_rx_clk,
    input  logic        rst,
    input  logic        gmii_rx_dv,
    input  logic [7:0]  gmii_rxd,
    output logic        hdr_vld,
    output logic [1:0]  frm_type,
    output logic [47:0] src_mac,
    output logic [31:0] src_ip,
    output logic        pay_en,
    output logic [7:0]  pay_data,
    output logic [15:0] pay_byte_num,
    output logic        frm_end,
    output logic        frm_drop
);

    localparam logic [7:0]  PRE_BYTE   = 8'h55;
    localparam logic [7:0]  SFD_BYTE   = 8'hD5;
    localparam logic [47:0] BCAST_MAC  = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [15:0] ETYPE_ARP  = 16'h0806;
    localparam logic [15:0] ETYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_VER_IHL = 8'h45;
    localparam logic [7:0]  PROTO_ICMP = 8'd1;
    localparam logic [7:0]  PROTO_UDP  = 8'd17;
    localparam logic [4:0]  MAX_PRE    = 5'd7;

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        PREAMBLE,
        ETH_HDR,
        IP_HDR,
        PAYLOAD,
        DROP
    } state_t;

    state_t      state, state_nxt;
    // Shared counter: preamble bytes seen in PREAMBLE, header byte index in ETH_HDR/IP_HDR.
    logic [4:0]  byte_cnt, byte_cnt_nxt;

    // Header capture; src_mac/src_ip outputs only load from these once a frame is accepted.
    logic [39:0] dst_sr;
    logic [47:0] mac_sr;
    logic [7:0]  type_hi;
    logic [1:0]  ip_class;
    logic [31:0] ip_sr;
    logic [23:0] dip_sr;
    logic [15:0] pay_cnt;

    // Full fields formed with the byte currently on the wire, used on the last byte of each field.
    logic [47:0] dst_full;
    logic [15:0] etype_full;
    logic [31:0] dip_full;

    // Per-cycle decisions taken by the FSM, registered into the outputs.
    logic        take_arp;
    logic        take_ip;
    logic        drop_now;
    logic        end_now;
    logic        pay_now;

    assign dst_full   = {dst_sr, gmii_rxd};
    assign etype_full = {type_hi, gmii_rxd};
    assign dip_full   = {dip_sr, gmii_rxd};

    // State and header byte counter register.
    always_ff @(posedge gmii_rx_clk) begin
        if (rst) begin
            state    <= WAIT_IDLE;
            byte_cnt <= 5'd0;
        end else begin
            state    <= state_nxt;
            byte_cnt <= byte_cnt_nxt;
        end
    end

    // Next-state logic and per-byte accept/drop decisions.
    always_comb begin
        state_nxt    = state;
        byte_cnt_nxt = byte_cnt;
        take_arp     = 1'b0;
        take_ip      = 1'b0;
        drop_now     = 1'b0;
        end_now      = 1'b0;
        pay_now      = 1'b0;
        case (state)
            // Never start mid-frame: wait for a gap after reset.
            WAIT_IDLE: begin
                if (!gmii_rx_dv) begin
                    state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (gmii_rx_dv) begin
                    if (gmii_rxd == PRE_BYTE) begin
                        state_nxt    = PREAMBLE;
                        byte_cnt_nxt = 5'd1;
                    end else begin
                        // Garbage outside a frame is silently skipped.
                        state_nxt = DROP;
                    end
                end
            end
            PREAMBLE: begin
                if (!gmii_rx_dv) begin
                    drop_now  = 1'b1;
                    state_nxt = IDLE;
                end else if (gmii_rxd == PRE_BYTE) begin
                    if (byte_cnt == MAX_PRE) begin
                        drop_now  = 1'b1;
                        state_nxt = DROP;
                    end else begin
                        byte_cnt_nxt = byte_cnt + 5'd1;
                    end
                end else if (gmii_rxd == SFD_BYTE) begin
                    state_nxt    = ETH_HDR;
                    byte_cnt_nxt = 5'd0;
                end else begin
                    drop_now  = 1'b1;
                    state_nxt = DROP;
                end
            end
            ETH_HDR: begin
                if (!gmii_rx_dv) begin
                    drop_now  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    byte_cnt_nxt = byte_cnt + 5'd1;
                    if (byte_cnt == 5'd5 && dst_full != BOARD_MAC && dst_full != BCAST_MAC) begin
                        drop_now  = 1'b1;
                        state_nxt = DROP;
                    end else if (byte_cnt == 5'd13) begin
                        if (etype_full == ETYPE_ARP) begin
                            take_arp  = 1'b1;
                            state_nxt = PAYLOAD;
                        end else if (etype_full == ETYPE_IPV4) begin
                            state_nxt    = IP_HDR;
                            byte_cnt_nxt = 5'd0;
                        end else begin
                            drop_now  = 1'b1;
                            state_nxt = DROP;
                        end
                    end
                end
            end
            IP_HDR: begin
                if (!gmii_rx_dv) begin
                    drop_now  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    byte_cnt_nxt = byte_cnt + 5'd1;
                    if (byte_cnt == 5'd0 && gmii_rxd != IP_VER_IHL) begin
                        drop_now  = 1'b1;
                        state_nxt = DROP;
                    end else if (byte_cnt == 5'd19) begin
                        // Protocol was latched at byte 9; both checks settle here.
                        if (ip_class != 2'd0 && dip_full == BOARD_IP) begin
                            take_ip   = 1'b1;
                            state_nxt = PAYLOAD;
                        end else begin
                            drop_now  = 1'b1;
                            state_nxt = DROP;
                        end
                    end
                end
            end
            PAYLOAD: begin
                if (gmii_rx_dv) begin
                    pay_now = 1'b1;
                end else begin
                    end_now   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            DROP: begin
                if (!gmii_rx_dv) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = WAIT_IDLE;
            end
        endcase
    end

    // Shift header fields in as they pass; only the byte index decides which field loads.
    always_ff @(posedge gmii_rx_clk) begin
        if (rst) begin
            dst_sr   <= 40'd0;
            mac_sr   <= 48'd0;
            type_hi  <= 8'd0;
            ip_class <= 2'd0;
            ip_sr    <= 32'd0;
            dip_sr   <= 24'd0;
        end else if (gmii_rx_dv) begin
            if (state == ETH_HDR) begin
                if (byte_cnt < 5'd5) begin
                    dst_sr <= {dst_sr[31:0], gmii_rxd};
                end
                if (byte_cnt >= 5'd6 && byte_cnt <= 5'd11) begin
                    mac_sr <= {mac_sr[39:0], gmii_rxd};
                end
                if (byte_cnt == 5'd12) begin
                    type_hi <= gmii_rxd;
                end
            end
            if (state == IP_HDR) begin
                if (byte_cnt == 5'd9) begin
                    if (gmii_rxd == PROTO_ICMP) begin
                        ip_class <= 2'd2;
                    end else if (gmii_rxd == PROTO_UDP) begin
                        ip_class <= 2'd3;
                    end else begin
                        ip_class <= 2'd0;
                    end
                end
                if (byte_cnt >= 5'd12 && byte_cnt <= 5'd15) begin
                    ip_sr <= {ip_sr[23:0], gmii_rxd};
                end
                if (byte_cnt >= 5'd16 && byte_cnt <= 5'd18) begin
                    dip_sr <= {dip_sr[15:0], gmii_rxd};
                end
            end
        end
    end

    // Registered outputs; classification fields only move on an accepted header.
    always_ff @(posedge gmii_rx_clk) begin
        if (rst) begin
            hdr_vld      <= 1'b0;
            frm_end      <= 1'b0;
            frm_drop     <= 1'b0;
            pay_en       <= 1'b0;
            pay_data     <= 8'd0;
            frm_type     <= 2'd0;
            src_mac      <= 48'd0;
            src_ip       <= 32'd0;
            pay_cnt      <= 16'd0;
            pay_byte_num <= 16'd0;
        end else begin
            hdr_vld  <= take_arp | take_ip;
            frm_end  <= end_now;
            frm_drop <= drop_now;
            pay_en   <= pay_now;
            if (pay_now) begin
                pay_data <= gmii_rxd;
            end
            if (take_arp) begin
                frm_type <= 2'd1;
                src_mac  <= mac_sr;
            end
            if (take_ip) begin
                frm_type <= ip_class;
                src_mac  <= mac_sr;
                src_ip   <= ip_sr;
            end
            // Count restarts with each new header and sticks at all-ones on jumbo streams.
            if (take_arp | take_ip) begin
                pay_cnt <= 16'd0;
            end else if (pay_now && pay_cnt != 16'hFFFF) begin
                pay_cnt <= pay_cnt + 16'd1;
            end
            if (end_now) begin
                pay_byte_num <= pay_cnt;
            end
        end
    end

endmodule

// File: tb/tb_eth_rx_dispatch.sv
// Bench for eth_rx_dispatch: table of frames with expected outcome, scoreboard queue of output events.
// Latency: expected events are queued as bytes are driven and popped when the DUT pulses.
// Backpressure: none; the DUT output stream is checked every cycle.
module tb_eth_rx_dispatch;

    localparam logic [47:0] BMAC = 48'h00_11_22_33_44_55;
    localparam logic [31:0] BIP  = 32'hC0A8010A;

    logic        gmii_rx_clk = 1'b0;
    logic        rst = 1'b1;
    logic        gmii_rx_dv = 1'b0;
    logic [7:0]  gmii_rxd = 8'd0;
    logic        hdr_vld;
    logic [1:0]  frm_type;
    logic [47:0] src_mac;
    logic [31:0] src_ip;
    logic        pay_en;
    logic [7:0]  pay_data;
    logic [15:0] pay_byte_num;
    logic        frm_end;
    logic        frm_drop;

    eth_rx_dispatch #(.BOARD_MAC(BMAC), .BOARD_IP(BIP)) dut (
        .gmii_rx_clk  (gmii_rx_clk),
        .rst          (rst),
        .gmii_rx_dv   (gmii_rx_dv),
        .gmii_rxd     (gmii_rxd),
        .hdr_vld      (hdr_vld),
        .frm_type     (frm_type),
        .src_mac      (src_mac),
        .src_ip       (src_ip),
        .pay_en       (pay_en),
        .pay_data     (pay_data),
        .pay_byte_num (pay_byte_num),
        .frm_end      (frm_end),
        .frm_drop     (frm_drop)
    );

    always #5 gmii_rx_clk = ~gmii_rx_clk;

    typedef struct {
        int          n55;
        logic [7:0]  sfd;
        logic [47:0] dst;
        logic [47:0] smac;
        logic [15:0] etype;
        logic [7:0]  ver;
        logic [7:0]  proto;
        logic [31:0] sip;
        logic [31:0] dip;
        int          npay;
        int          trunc;    // bytes sent before dv drops, -1 = whole frame
        bit          acc;      // expect hdr_vld/payload/frm_end
        logic [1:0]  etyp;     // expected frm_type when accepted
        int          drop_at;  // stream index whose edge pulses frm_drop, -1 = none
        int          rst_at;   // stream index driven together with rst, -1 = none
    } vec_t;

    localparam int EV_HDR = 0, EV_PAY = 1, EV_END = 2, EV_DROP = 3;

    typedef struct {
        int          kind;
        logic [1:0]  typ;
        logic [47:0] mac;
        logic [31:0] ip;
        logic [15:0] num;
        logic [7:0]  dat;
    } ev_t;

    ev_t         sb[$];
    logic [7:0]  frm[$];
    vec_t        vecs[16];
    int          checks = 0;
    int          errors = 0;
    int          cur_vec = -1;
    bit          mon_en = 1'b0;
    // Model of the held classification outputs.
    logic [1:0]  m_type = 2'd0;
    logic [47:0] m_mac = 48'd0;
    logic [31:0] m_ip = 32'd0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (vec %0d): got %0h expected %0h", nm, cur_vec, act, exp);
        end
    endtask

    task automatic pop_ev(input int kind, output ev_t e, output bit ok);
        ok = 1'b0;
        e = '{default: '0};
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event (vec %0d): got kind %0d expected none", cur_vec, kind);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind) begin
                errors++;
                $display("FAIL event_order (vec %0d): got kind %0d expected kind %0d", cur_vec, kind, e.kind);
            end else begin
                ok = 1'b1;
            end
        end
    endtask

    task automatic push_ev(input int kind, input logic [15:0] num, input logic [7:0] dat);
        ev_t e;
        e.kind = kind;
        e.typ  = m_type;
        e.mac  = m_mac;
        e.ip   = m_ip;
        e.num  = num;
        e.dat  = dat;
        sb.push_back(e);
    endtask

    // Output monitor, sampling on the falling edge.
    always @(negedge gmii_rx_clk) begin
        ev_t e;
        bit  ok;
        if (mon_en) begin
            if (hdr_vld || frm_end || frm_drop) begin
                chk("pulse_exclusive", 64'(int'(hdr_vld) + int'(frm_end) + int'(frm_drop)), 64'd1);
            end
            if (hdr_vld) begin
                pop_ev(EV_HDR, e, ok);
                if (ok) begin
                    chk("hdr_frm_type", 64'(frm_type), 64'(e.typ));
                    chk("hdr_src_mac", 64'(src_mac), 64'(e.mac));
                    chk("hdr_src_ip", 64'(src_ip), 64'(e.ip));
                end
            end
            if (pay_en) begin
                pop_ev(EV_PAY, e, ok);
                if (ok) chk("pay_data", 64'(pay_data), 64'(e.dat));
            end
            if (frm_end) begin
                pop_ev(EV_END, e, ok);
                if (ok) chk("pay_byte_num", 64'(pay_byte_num), 64'(e.num));
            end
            if (frm_drop) begin
                pop_ev(EV_DROP, e, ok);
                if (ok) begin
                    chk("drop_frm_type_held", 64'(frm_type), 64'(e.typ));
                    chk("drop_src_mac_held", 64'(src_mac), 64'(e.mac));
                    chk("drop_src_ip_held", 64'(src_ip), 64'(e.ip));
                end
            end
        end
    end

    task automatic build(input vec_t v);
        frm.delete();
        for (int k = 0; k < v.n55; k++) frm.push_back(8'h55);
        frm.push_back(v.sfd);
        for (int k = 0; k < 6; k++) frm.push_back(v.dst[47-8*k -: 8]);
        for (int k = 0; k < 6; k++) frm.push_back(v.smac[47-8*k -: 8]);
        frm.push_back(v.etype[15:8]);
        frm.push_back(v.etype[7:0]);
        if (v.etype == 16'h0800) begin
            for (int k = 0; k < 20; k++) begin
                if (k == 0) frm.push_back(v.ver);
                else if (k == 8) frm.push_back(8'd64);
                else if (k == 9) frm.push_back(v.proto);
                else if (k >= 12 && k <= 15) frm.push_back(v.sip[31-8*(k-12) -: 8]);
                else if (k >= 16) frm.push_back(v.dip[31-8*(k-16) -: 8]);
                else frm.push_back(8'(k * 3));
            end
        end
        for (int k = 0; k < v.npay; k++) frm.push_back(8'(k * 37 + 5));
    endtask

    task automatic run_frame(input vec_t v);
        int n, hdr_idx, pcount;
        bit killed;
        build(v);
        n = (v.trunc >= 0) ? v.trunc : frm.size();
        hdr_idx = (v.etyp == 2'd1) ? v.n55 + 14 : v.n55 + 34;
        pcount = 0;
        killed = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge gmii_rx_clk);
            rst = 1'b0;
            gmii_rx_dv = 1'b1;
            gmii_rxd = frm[i];
            if (i == v.rst_at) begin
                rst = 1'b1;
                killed = 1'b1;
                m_type = 2'd0;
                m_mac = 48'd0;
                m_ip = 32'd0;
            end
            if (!killed) begin
                if (v.acc && i == hdr_idx) begin
                    m_type = v.etyp;
                    m_mac = v.smac;
                    if (v.etyp != 2'd1) m_ip = v.sip;
                    push_ev(EV_HDR, 16'd0, 8'd0);
                end
                if (v.acc && i > hdr_idx) begin
                    push_ev(EV_PAY, 16'd0, frm[i]);
                    pcount++;
                end
                if (i == v.drop_at) push_ev(EV_DROP, 16'd0, 8'd0);
            end
        end
        @(negedge gmii_rx_clk);
        rst = 1'b0;
        gmii_rx_dv = 1'b0;
        gmii_rxd = 8'd0;
        if (v.acc && !killed) push_ev(EV_END, 16'(pcount), 8'd0);
        if (v.drop_at == n && !killed) push_ev(EV_DROP, 16'd0, 8'd0);
        repeat (12) @(negedge gmii_rx_clk);
        chk("events_outstanding", 64'(sb.size()), 64'd0);
        sb.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        //          n55 sfd    dst                 smac                etype     ver    proto   sip           dip           npay trunc acc typ drop rst
        vecs[0]  = '{7, 8'hD5, 48'hFFFF_FFFF_FFFF, 48'h000A_3501_FEC0, 16'h0806, 8'h00, 8'd0,  32'h0,        32'h0,        32, -1, 1'b1, 2'd1, -1, -1};
        vecs[1]  = '{7, 8'hD5, BMAC,               48'h02AA_BBCC_DDEE, 16'h0800, 8'h45, 8'd17, 32'hC0A80166, BIP,          22, -1, 1'b1, 2'd3, -1, -1};
        vecs[2]  = '{7, 8'hD5, BMAC,               48'h0211_1111_1111, 16'h0800, 8'h45, 8'd1,  32'hC0A80109, 32'hC0A8010B, 10, -1, 1'b0, 2'd0, 41, -1};
        vecs[3]  = '{7, 8'hD5, BMAC,               48'h0233_4455_6677, 16'h0800, 8'h45, 8'd1,  32'hC0A80105, BIP,          12, -1, 1'b1, 2'd2, -1, -1};
        vecs[4]  = '{7, 8'hD5, BMAC,               48'h0299_8877_6655, 16'h0800, 8'h45, 8'd17, 32'hC0A80177, BIP,          22, 17, 1'b0, 2'd0, 17, -1};
        vecs[5]  = '{7, 8'hD5, BMAC,               48'h02AB_CDEF_0123, 16'h0800, 8'h45, 8'd17, 32'hC0A80167, BIP,          18, -1, 1'b1, 2'd3, -1, -1};
        vecs[6]  = '{7, 8'hD5, BMAC,               48'h0244_4444_4444, 16'h0800, 8'h46, 8'd17, 32'hC0A80168, BIP,          10, -1, 1'b0, 2'd0, 22, -1};
        vecs[7]  = '{7, 8'hD5, BMAC,               48'h0255_5555_5555, 16'h86DD, 8'h00, 8'd0,  32'h0,        32'h0,        30, -1, 1'b0, 2'd0, 21, -1};
        vecs[8]  = '{7, 8'hD5, 48'h0011_2233_445A, 48'h0266_6666_6666, 16'h0806, 8'h00, 8'd0,  32'h0,        32'h0,        28, -1, 1'b0, 2'd0, 13, -1};
        vecs[9]  = '{8, 8'hD5, 48'hFFFF_FFFF_FFFF, 48'h0277_7777_7777, 16'h0806, 8'h00, 8'd0,  32'h0,        32'h0,        28, -1, 1'b0, 2'd0, 7,  -1};
        vecs[10] = '{1, 8'hD5, BMAC,               48'h0288_8888_8888, 16'h0806, 8'h00, 8'd0,  32'h0,        32'h0,        0,  -1, 1'b1, 2'd1, -1, -1};
        vecs[11] = '{3, 8'hD4, BMAC,               48'h0299_9999_9999, 16'h0806, 8'h00, 8'd0,  32'h0,        32'h0,        28, -1, 1'b0, 2'd0, 3,  -1};
        vecs[12] = '{0, 8'hD5, BMAC,               48'h02AA_AAAA_AAAA, 16'h0806, 8'h00, 8'd0,  32'h0,        32'h0,        28, -1, 1'b0, 2'd0, -1, -1};
        vecs[13] = '{7, 8'hD5, BMAC,               48'h02BB_BBBB_BBBB, 16'h0800, 8'h45, 8'd6,  32'hC0A80169, BIP,          20, -1, 1'b0, 2'd0, 41, -1};
        vecs[14] = '{7, 8'hD5, BMAC,               48'h02CC_CCCC_CCCC, 16'h0800, 8'h45, 8'd17, 32'hC0A8016A, BIP,          20, 32, 1'b0, 2'd0, 32, -1};
        vecs[15] = '{7, 8'hD5, BMAC,               48'h02DD_DDDD_DDDD, 16'h0806, 8'h00, 8'd0,  32'h0,        32'h0,        28, 4,  1'b0, 2'd0, 4,  -1};

        // Reset values.
        rst = 1'b1;
        repeat (3) @(negedge gmii_rx_clk);
        chk("rst_hdr_vld", 64'(hdr_vld), 64'd0);
        chk("rst_frm_type", 64'(frm_type), 64'd0);
        chk("rst_src_mac", 64'(src_mac), 64'd0);
        chk("rst_src_ip", 64'(src_ip), 64'd0);
        chk("rst_pay_en", 64'(pay_en), 64'd0);
        chk("rst_pay_data", 64'(pay_data), 64'd0);
        chk("rst_pay_byte_num", 64'(pay_byte_num), 64'd0);
        chk("rst_frm_end", 64'(frm_end), 64'd0);
        chk("rst_frm_drop", 64'(frm_drop), 64'd0);
        mon_en = 1'b1;

        // Reset released in the middle of a valid frame: it must be ignored until dv drops.
        build(vecs[0]);
        gmii_rx_dv = 1'b1;
        gmii_rxd = frm[0];
        @(negedge gmii_rx_clk);
        rst = 1'b0;
        for (int i = 1; i < frm.size(); i++) begin
            gmii_rxd = frm[i];
            @(negedge gmii_rx_clk);
        end
        gmii_rx_dv = 1'b0;
        gmii_rxd = 8'd0;
        repeat (12) @(negedge gmii_rx_clk);
        chk("wait_idle_quiet", 64'(sb.size()), 64'd0);

        for (int t = 0; t < 16; t++) begin
            cur_vec = t;
            run_frame(vecs[t]);
        end

        // Reset pulsed on UDP payload byte 3 with dv held high, then a normal frame.
        cur_vec = 100;
        v = vecs[1];
        v.rst_at = v.n55 + 34 + 4;
        run_frame(v);
        chk("midrst_frm_type", 64'(frm_type), 64'd0);
        chk("midrst_src_mac", 64'(src_mac), 64'd0);
        chk("midrst_src_ip", 64'(src_ip), 64'd0);
        chk("midrst_pay_byte_num", 64'(pay_byte_num), 64'd0);
        cur_vec = 101;
        run_frame(vecs[5]);
        chk("after_rst_frm_type", 64'(frm_type), 64'd3);
        chk("after_rst_src_ip", 64'(src_ip), 64'hC0A80167);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
